// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port among num_req_p requesters.
// Grants rotate round-robin and only one transaction is in flight at a time.
// A sticky watchdog error flags a memory that stops responding.
module dmem_arbiter #(
  parameter int num_req_p   = 2,
  parameter int timeout_p   = 255,
  parameter int cnt_width_p = 8
) (
  input  logic                           clk,
  input  logic                           n_reset,
  input  logic [num_req_p-1:0]           req_valid_i,
  input  logic [num_req_p-1:0][31:0]     req_addr_i,
  input  logic [num_req_p-1:0][31:0]     req_wdata_i,
  input  logic [num_req_p-1:0]           req_wen_i,
  input  logic [num_req_p-1:0]           req_byte_i,
  output logic [num_req_p-1:0]           req_yumi_o,
  output logic [num_req_p-1:0]           resp_valid_o,
  output logic [31:0]                    resp_data_o,
  input  logic [num_req_p-1:0]           resp_yumi_i,
  output logic                           mem_valid_o,
  output logic [31:0]                    mem_addr_o,
  output logic [31:0]                    mem_wdata_o,
  output logic                           mem_wen_o,
  output logic                           mem_byte_o,
  input  logic                           mem_yumi_i,
  input  logic                           mem_valid_i,
  input  logic [31:0]                    mem_rdata_i,
  output logic                           mem_yumi_o,
  output logic [$clog2(num_req_p)-1:0]   owner_o,
  output logic                           err_o
);

  localparam int idx_width_lp = $clog2(num_req_p);
  typedef logic [idx_width_lp-1:0] idx_t;
  typedef logic [cnt_width_p-1:0]  cnt_t;

  localparam idx_t last_idx_lp   = idx_t'(num_req_p - 1);
  localparam cnt_t timeout_lp    = cnt_t'(timeout_p);
  localparam cnt_t timeout_m1_lp = cnt_t'(timeout_p - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_e;

  state_e      state_r, state_n;
  idx_t        last_grant_r, owner_r;
  idx_t        grant_idx, rr_cand;
  logic        grant_found;
  logic [31:0] addr_r, wdata_r;
  logic        wen_r, byte_r;
  cnt_t        cnt_r;
  logic        err_r;
  logic        resp_window, resp_done;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    rr_cand     = '0;
    for (int i = 1; i <= num_req_p; i++) begin
      rr_cand = idx_t'((int'(last_grant_r) + i) % num_req_p);
      if (!grant_found && req_valid_i[rr_cand]) begin
        grant_found = 1'b1;
        grant_idx   = rr_cand;
      end
    end
  end

  // The response path is live once memory has taken the request.
  assign resp_window = (state_r == WAIT) || ((state_r == SEND) && mem_yumi_i);
  assign resp_done   = resp_window && mem_valid_i && resp_yumi_i[owner_r];

  // State register.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic: IDLE grants, SEND waits for memory accept, WAIT for the response.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: if (grant_found) state_n = SEND;
      SEND: if (mem_yumi_i) state_n = resp_done ? IDLE : WAIT;
      WAIT: if (resp_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output logic: request accept, memory valid and the one-hot response steering.
  always_comb begin
    req_yumi_o   = '0;
    resp_valid_o = '0;
    mem_yumi_o   = 1'b0;
    mem_valid_o  = (state_r == SEND);
    if ((state_r == IDLE) && grant_found) begin
      req_yumi_o[grant_idx] = 1'b1;
    end
    if (resp_window) begin
      resp_valid_o[owner_r] = mem_valid_i;
      mem_yumi_o            = resp_done;
    end
  end

  // Capture the granted request so later input changes cannot disturb it.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      addr_r       <= '0;
      wdata_r      <= '0;
      wen_r        <= 1'b0;
      byte_r       <= 1'b0;
      owner_r      <= '0;
      last_grant_r <= last_idx_lp;
    end else if ((state_r == IDLE) && grant_found) begin
      addr_r       <= req_addr_i[grant_idx];
      wdata_r      <= req_wdata_i[grant_idx];
      wen_r        <= req_wen_i[grant_idx];
      byte_r       <= req_byte_i[grant_idx];
      owner_r      <= grant_idx;
      last_grant_r <= grant_idx;
    end
  end

  // Watchdog: count busy cycles, saturate, and latch the error when the limit is reached.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      cnt_r <= '0;
      err_r <= 1'b0;
    end else if (state_r == IDLE) begin
      cnt_r <= '0;
    end else begin
      if (cnt_r != timeout_lp) begin
        cnt_r <= cnt_r + cnt_t'(1);
      end
      if (cnt_r >= timeout_m1_lp) begin
        err_r <= 1'b1;
      end
    end
  end

  assign mem_addr_o  = addr_r;
  assign mem_wdata_o = wdata_r;
  assign mem_wen_o   = wen_r;
  assign mem_byte_o  = byte_r;
  assign resp_data_o = mem_rdata_i;
  assign owner_o     = owner_r;
  assign err_o       = err_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized traffic, all checked each
// cycle against a transaction-level model of the arbiter.
module tb_dmem_arbiter;

  localparam int N       = 2;
  localparam int TIMEOUT = 255;

  logic              clk = 1'b0;
  logic              n_reset;
  logic [N-1:0]      req_valid, req_wen, req_byte, req_yumi;
  logic [N-1:0]      resp_valid, resp_yumi;
  logic [N-1:0][31:0] req_addr, req_wdata;
  logic [31:0]       resp_data, mem_addr, mem_wdata, mem_rdata;
  logic              mem_valid, mem_wen, mem_byte, mem_yumi_in, mem_valid_in, mem_yumi_out;
  logic [$clog2(N)-1:0] owner;
  logic              err;

  int checks   = 0;
  int failures = 0;

  // Transaction-level model state.
  bit          model_valid = 1'b0;
  bit          m_busy, m_accepted, m_err;
  int          m_owner, m_last, m_cycles;
  logic [31:0] m_addr, m_wdata;
  logic        m_wen, m_byte;

  // Expected outputs for the current cycle.
  int          exp_grant;
  logic [N-1:0] exp_req_yumi, exp_resp_valid;
  logic        exp_mem_valid, exp_mem_yumi;

  // Snapshot of DUT outputs taken at the compare point.
  logic [N-1:0] snap_req_yumi, snap_resp_valid;
  logic [31:0]  snap_resp_data, snap_mem_addr, snap_mem_wdata;
  logic         snap_mem_valid, snap_mem_wen, snap_mem_byte, snap_mem_yumi, snap_err;
  int           snap_owner;

  bit [N-1:0] pending;

  dmem_arbiter #(.num_req_p(N), .timeout_p(TIMEOUT), .cnt_width_p(8)) dut (
    .clk(clk), .n_reset(n_reset),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_wen_i(req_wen), .req_byte_i(req_byte), .req_yumi_o(req_yumi),
    .resp_valid_o(resp_valid), .resp_data_o(resp_data), .resp_yumi_i(resp_yumi),
    .mem_valid_o(mem_valid), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_wen_o(mem_wen), .mem_byte_o(mem_byte), .mem_yumi_i(mem_yumi_in),
    .mem_valid_i(mem_valid_in), .mem_rdata_i(mem_rdata), .mem_yumi_o(mem_yumi_out),
    .owner_o(owner), .err_o(err)
  );

  always #5 clk = ~clk;

  function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endfunction

  function automatic void resetModel();
    m_busy = 0; m_accepted = 0; m_err = 0;
    m_owner = 0; m_last = N - 1; m_cycles = 0;
    m_addr = '0; m_wdata = '0; m_wen = 0; m_byte = 0;
  endfunction

  // Derive what the outputs must be from the model and the current inputs.
  function automatic void computeExpected();
    bit window;
    exp_grant = -1;
    if (!m_busy) begin
      for (int k = 1; k <= N; k++) begin
        int c = (m_last + k) % N;
        if (exp_grant < 0 && req_valid[c]) exp_grant = c;
      end
    end
    exp_req_yumi = '0;
    if (exp_grant >= 0) exp_req_yumi[exp_grant] = 1'b1;
    exp_mem_valid = m_busy && !m_accepted;
    window = m_busy && (m_accepted || mem_yumi_in);
    exp_resp_valid = '0;
    if (window && mem_valid_in) exp_resp_valid[m_owner] = 1'b1;
    exp_mem_yumi = window && mem_valid_in && resp_yumi[m_owner];
  endfunction

  function automatic void checkOutput();
    computeExpected();
    snap_req_yumi = req_yumi;  snap_resp_valid = resp_valid; snap_resp_data = resp_data;
    snap_mem_valid = mem_valid; snap_mem_addr = mem_addr; snap_mem_wdata = mem_wdata;
    snap_mem_wen = mem_wen; snap_mem_byte = mem_byte; snap_mem_yumi = mem_yumi_out;
    snap_owner = int'(owner); snap_err = err;
    if (model_valid) begin
      cmp("req_yumi", 32'(req_yumi), 32'(exp_req_yumi));
      cmp("resp_valid", 32'(resp_valid), 32'(exp_resp_valid));
      cmp("resp_data", resp_data, mem_rdata);
      cmp("mem_valid", 32'(mem_valid), 32'(exp_mem_valid));
      cmp("mem_addr", mem_addr, m_addr);
      cmp("mem_wdata", mem_wdata, m_wdata);
      cmp("mem_wen", 32'(mem_wen), 32'(m_wen));
      cmp("mem_byte", 32'(mem_byte), 32'(m_byte));
      cmp("mem_yumi", 32'(mem_yumi_out), 32'(exp_mem_yumi));
      cmp("owner", 32'(owner), 32'(m_owner));
      cmp("err", 32'(err), 32'(m_err));
    end
  endfunction

  // Move the model to what must hold after the coming clock edge.
  function automatic void advanceModel();
    if (!n_reset) begin
      resetModel();
      model_valid = 1'b1;
    end else if (!m_busy) begin
      if (exp_grant >= 0) begin
        m_busy = 1; m_accepted = 0; m_cycles = 0;
        m_owner = exp_grant; m_last = exp_grant;
        m_addr = req_addr[exp_grant]; m_wdata = req_wdata[exp_grant];
        m_wen = req_wen[exp_grant]; m_byte = req_byte[exp_grant];
      end
    end else begin
      if (m_cycles < TIMEOUT) m_cycles++;
      if (m_cycles >= TIMEOUT) m_err = 1;
      if (exp_mem_yumi) m_busy = 0;
      else if (mem_yumi_in) m_accepted = 1;
    end
  endfunction

  task automatic step();
    @(negedge clk);
    checkOutput();
    advanceModel();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    req_valid = '0; req_wen = '0; req_byte = '0; req_addr = '0; req_wdata = '0;
    resp_yumi = '0; mem_yumi_in = 0; mem_valid_in = 0; mem_rdata = '0;
  endtask

  task automatic doReset();
    n_reset = 0;
    step();
    n_reset = 1;
  endtask

  // Random traffic: requesters hold requests until accepted, memory is erratic.
  task automatic applyStimulus();
    for (int i = 0; i < N; i++) begin
      if (pending[i] && exp_req_yumi[i]) pending[i] = 0;
      if (!pending[i] && ($urandom_range(3) == 0)) begin
        pending[i] = 1;
        req_addr[i] = $urandom; req_wdata[i] = $urandom;
        req_wen[i] = 1'($urandom); req_byte[i] = 1'($urandom);
      end else if (!pending[i]) begin
        req_addr[i] = $urandom; req_wdata[i] = $urandom;
        req_wen[i] = 1'($urandom); req_byte[i] = 1'($urandom);
      end
      req_valid[i] = pending[i];
    end
    resp_yumi    = N'($urandom);
    mem_yumi_in  = ($urandom_range(2) == 0);
    mem_valid_in = ($urandom_range(2) == 0);
    mem_rdata    = $urandom;
    n_reset      = ($urandom_range(399) != 0);
  endtask

  initial begin
    logic [N-1:0] alt_exp [8];
    clearInputs();
    n_reset = 0;
    @(posedge clk); #1;
    doReset();
    for (int i = 0; i < 10; i++) step();
    cmp("idle_req_yumi", 32'(snap_req_yumi), 32'h0);
    cmp("idle_mem_valid", 32'(snap_mem_valid), 32'h0);
    cmp("idle_resp_valid", 32'(snap_resp_valid), 32'h0);
    cmp("idle_owner", 32'(snap_owner), 32'h0);
    cmp("idle_err", 32'(snap_err), 32'h0);

    // Requester 0 loads 0x10.
    req_valid = 2'b01; req_addr[0] = 32'h10;
    step();
    cmp("load_yumi", 32'(snap_req_yumi), 32'h1);
    req_valid = '0; req_addr[0] = 32'h999;
    for (int c = 1; c <= 3; c++) begin
      mem_yumi_in = (c == 3);
      step();
      cmp("load_mem_valid", 32'(snap_mem_valid), 32'h1);
      cmp("load_mem_addr", snap_mem_addr, 32'h10);
      cmp("load_mem_wen", 32'(snap_mem_wen), 32'h0);
    end
    mem_yumi_in = 0;
    step(); step();
    cmp("load_wait_mem_valid", 32'(snap_mem_valid), 32'h0);
    mem_valid_in = 1; mem_rdata = 32'hDEADBEEF; resp_yumi = 2'b01;
    step();
    cmp("load_resp_valid", 32'(snap_resp_valid), 32'h1);
    cmp("load_resp_data", snap_resp_data, 32'hDEADBEEF);
    cmp("load_mem_yumi", 32'(snap_mem_yumi), 32'h1);
    clearInputs();
    step();
    cmp("load_done_mem_valid", 32'(snap_mem_valid), 32'h0);

    // Both requesters contend; memory answers immediately.
    doReset();
    alt_exp = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    req_valid = 2'b11; mem_yumi_in = 1; mem_valid_in = 1; resp_yumi = 2'b11;
    for (int c = 0; c < 8; c++) begin
      step();
      cmp("alt_yumi", 32'(snap_req_yumi), 32'(alt_exp[c]));
    end
    clearInputs();

    // Requester 1 stores byte 0xAB to 0x7.
    req_valid = 2'b10; req_addr[1] = 32'h7; req_wdata[1] = 32'hAB; req_wen = 2'b10; req_byte = 2'b10;
    step();
    cmp("store_yumi", 32'(snap_req_yumi), 32'h2);
    clearInputs(); req_addr[1] = 32'h55; mem_yumi_in = 1;
    step();
    cmp("store_mem_wen", 32'(snap_mem_wen), 32'h1);
    cmp("store_mem_byte", 32'(snap_mem_byte), 32'h1);
    cmp("store_mem_wdata", snap_mem_wdata, 32'hAB);
    cmp("store_mem_addr", snap_mem_addr, 32'h7);
    mem_yumi_in = 0; mem_valid_in = 1; resp_yumi = 2'b10;
    step();
    cmp("store_resp_valid", 32'(snap_resp_valid), 32'h2);
    cmp("store_mem_yumi", 32'(snap_mem_yumi), 32'h1);
    clearInputs();
    step();

    // Owner withholds its response yumi.
    req_valid = 2'b01; req_addr[0] = 32'h20;
    step();
    clearInputs(); mem_yumi_in = 1;
    step();
    mem_yumi_in = 0; mem_valid_in = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      cmp("hold_resp_valid", 32'(snap_resp_valid), 32'h1);
      cmp("hold_mem_yumi", 32'(snap_mem_yumi), 32'h0);
    end
    resp_yumi = 2'b01;
    step();
    cmp("hold_release_mem_yumi", 32'(snap_mem_yumi), 32'h1);
    clearInputs();
    step();

    // Memory never accepts: watchdog fires, then reset recovers.
    req_valid = 2'b10; req_addr[1] = 32'h44;
    step();
    clearInputs();
    for (int k = 1; k <= TIMEOUT + 1; k++) begin
      step();
      if (k == TIMEOUT) cmp("wd_err_before", 32'(snap_err), 32'h0);
    end
    cmp("wd_err_after", 32'(snap_err), 32'h1);
    cmp("wd_still_sending", 32'(snap_mem_valid), 32'h1);
    cmp("wd_owner", 32'(snap_owner), 32'h1);
    doReset();
    step();
    cmp("wd_reset_err", 32'(snap_err), 32'h0);
    cmp("wd_reset_owner", 32'(snap_owner), 32'h0);
    cmp("wd_reset_mem_valid", 32'(snap_mem_valid), 32'h0);

    // Randomized traffic against the model.
    pending = '0;
    exp_req_yumi = '0;
    for (int c = 0; c < 3000; c++) begin
      applyStimulus();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
